// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin two-port arbiter sequencing an async SRAM bus with setup/strobe/hold wait states
// ports: req/we/addr/wdata/ack per requester 0 and 1; rdata holds the last read;
// sram_addr/sram_dout/sram_doe/sram_din, ncs/nwe/noe connect to the tristate pad buffer
module sram_arbiter #(
  parameter int AW   = 10,
  parameter int DW   = 16,
  parameter int TSET = 3,
  parameter int NWS  = 3,
  parameter int THLD = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  input  logic [DW-1:0] sram_din,
  output logic          sram_doe,
  output logic          ncs,
  output logic          nwe,
  output logic          noe
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic last_grant, dir, grant, pick1, busy_n, strobe_n;
  // bus outputs are registered from the next state so they change on the same edge as the state
  always_comb begin
    pick1 = req1 && (!req0 || !last_grant);
    grant = state == IDLE && (req0 || req1);
    state_n = state;
    cnt_n = cnt - 4'd1;
    case (state)
      IDLE: begin
        state_n = grant ? SETUP : IDLE;
        cnt_n = 4'(TSET - 1);
      end
      SETUP: if (cnt == 4'd0) begin
        state_n = STROBE;
        cnt_n = 4'(NWS - 1);
      end
      STROBE: if (cnt == 4'd0) begin
        state_n = HOLD;
        cnt_n = 4'(THLD - 1);
      end
      HOLD: state_n = cnt == 4'd0 ? TURN : HOLD;
      TURN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = state_n inside {SETUP, STROBE, HOLD};
    strobe_n = state_n == STROBE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      last_grant <= 1'b1;
      dir <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata <= '0;
      sram_addr <= '0;
      sram_dout <= '0;
      sram_doe <= 1'b0;
      ncs <= 1'b1;
      nwe <= 1'b1;
      noe <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (grant) begin
        last_grant <= pick1;
        dir <= pick1 ? we1 : we0;
        sram_addr <= pick1 ? addr1 : addr0;
        sram_dout <= pick1 ? wdata1 : wdata0;
      end
      if (state == STROBE && cnt == 4'd0 && !dir) rdata <= sram_din;
      ncs <= !busy_n;
      nwe <= !(strobe_n && dir);
      noe <= !(strobe_n && !dir);
      sram_doe <= dir && (strobe_n || state_n == HOLD);
      ack0 <= state_n == TURN && !last_grant;
      ack1 <= state_n == TURN && last_grant;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and randomized checks of sram_arbiter against a cycle-count transaction model
module tb_sram_arbiter;
  localparam int TSET = 3, NWS = 3, THLD = 3;
  localparam int T = TSET + NWS + THLD;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, we0 = 0, req1 = 0, we1 = 0;
  logic [9:0] addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0, din_val = '0;
  logic ack0, ack1, sram_doe, ncs, nwe, noe;
  logic [15:0] rdata, sram_dout, sram_din;
  logic [9:0] sram_addr;
  int checks = 0, failures = 0;
  logic mlg = 1'b1;
  logic [15:0] mrd = '0;
  assign sram_din = noe ? 16'h0000 : din_val;
  always #5 clk = ~clk;
  sram_arbiter #(.AW(10), .DW(16), .TSET(TSET), .NWS(NWS), .THLD(THLD)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_doe(sram_doe), .ncs(ncs), .nwe(nwe), .noe(noe)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, o, e, $time);
    end
  endtask
  task automatic chk_idle();
    chk("idle_ncs", 32'(ncs), 32'(1));
    chk("idle_nwe", 32'(nwe), 32'(1));
    chk("idle_noe", 32'(noe), 32'(1));
    chk("idle_doe", 32'(sram_doe), 32'(0));
    chk("idle_ack0", 32'(ack0), 32'(0));
    chk("idle_ack1", 32'(ack1), 32'(0));
    chk("idle_rdata", 32'(rdata), 32'(mrd));
  endtask
  // Requests present at call time are granted on the next rising edge (cycle 0);
  // returns at the falling edge of the following IDLE cycle (T+2).
  task automatic txn();
    logic w, we_e, strobe;
    logic [9:0] a_e;
    logic [15:0] d_e;
    w = req1 && (!req0 || !mlg);
    mlg = w;
    we_e = w ? we1 : we0;
    a_e = w ? addr1 : addr0;
    d_e = w ? wdata1 : wdata0;
    for (int k = 1; k <= T + 2; k++) begin
      @(negedge clk);
      strobe = k > TSET && k <= TSET + NWS;
      if (!we_e && k == TSET + NWS + 1) mrd = din_val;
      chk("ncs", 32'(ncs), 32'(!(k <= T)));
      chk("nwe", 32'(nwe), 32'(!(strobe && we_e)));
      chk("noe", 32'(noe), 32'(!(strobe && !we_e)));
      chk("doe", 32'(sram_doe), 32'(we_e && k > TSET && k <= T));
      chk("ack0", 32'(ack0), 32'(k == T + 1 && !w));
      chk("ack1", 32'(ack1), 32'(k == T + 1 && w));
      chk("addr", 32'(sram_addr), 32'(a_e));
      chk("dout", 32'(sram_dout), 32'(d_e));
      chk("rdata", 32'(rdata), 32'(mrd));
      if (k == T + 1) begin
        if (w) req1 = 1'b0;
        else req0 = 1'b0;
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(sram_addr), 32'(0));
    chk("rst_dout", 32'(sram_dout), 32'(0));
    chk_idle();
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk_idle();
    end
    req0 = 1; we0 = 1; addr0 = 10'h005; wdata0 = 16'h000F;
    txn();
    req1 = 1; we1 = 0; addr1 = 10'h3FF; din_val = 16'hBEEF;
    txn();
    repeat (3) begin
      @(negedge clk);
      chk_idle();
    end
    chk("rdata_beef", 32'(rdata), 32'h0000BEEF);
    req0 = 1; we0 = 1; addr0 = 10'h0A5; wdata0 = 16'h1234;
    req1 = 1; we1 = 0; addr1 = 10'h15A; din_val = 16'h5A5A;
    txn();
    chk("tie_first_ack0_done", 32'(req1), 32'(1));
    txn();
    for (int i = 0; i < 10; i++) begin
      req0 = 1; we0 = 1; addr0 = 10'(i); wdata0 = 16'(3 * i);
      txn();
    end
    req0 = 1; we0 = 1; addr0 = 10'h012; wdata0 = 16'hABCD;
    repeat (TSET + 2) @(negedge clk);
    chk("pre_rst_nwe", 32'(nwe), 32'(0));
    reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    mlg = 1'b1; mrd = '0;
    chk("mid_rst_addr", 32'(sram_addr), 32'(0));
    chk("mid_rst_dout", 32'(sram_dout), 32'(0));
    chk_idle();
    reset = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk_idle();
    end
    req0 = 1; we0 = 0; addr0 = 10'h2C3; din_val = 16'hC0DE;
    txn();
    for (int n = 0; n < 40; n++) begin
      if (!req0 && $urandom_range(0, 1) == 1) begin
        req0 = 1; we0 = 1'($urandom); addr0 = 10'($urandom); wdata0 = 16'($urandom);
      end
      if (!req1 && $urandom_range(0, 1) == 1) begin
        req1 = 1; we1 = 1'($urandom); addr1 = 10'($urandom); wdata1 = 16'($urandom);
      end
      if (!req0 && !req1) begin
        req1 = 1; we1 = 1'($urandom); addr1 = 10'($urandom); wdata1 = 16'($urandom);
      end
      din_val = 16'($urandom);
      txn();
    end
    req0 = 0; req1 = 0;
    repeat (T + 3) begin
      @(negedge clk);
      chk_idle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
